// File: rtl/score_display.sv
// Pac-Man scoring stage: event FIFO, digit-serial BCD adder and eight 7-segment displays.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_display #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_score_reset,
  input  logic        i_item_eaten,
  input  logic [1:0]  i_item_eaten_type,
  input  logic        i_ghost_eaten,
  input  logic [7:0]  i_level,
`ifdef SCORE_HISCORE_EN
  input  logic        i_show_hiscore,
  output logic [23:0] o_hiscore,
`endif
  output logic [23:0] o_score,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [6:0]  o_hex0,
  output logic [6:0]  o_hex1,
  output logic [6:0]  o_hex2,
  output logic [6:0]  o_hex3,
  output logic [6:0]  o_hex4,
  output logic [6:0]  o_hex5,
  output logic [6:0]  o_hex6,
  output logic [6:0]  o_hex7,
  output logic        o_dbg_adding
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_ADD} state_t;

  state_t          state_q, state_d;
  logic [2:0]      digit_q, digit_d;
  logic            carry_q, carry_d;
  logic [23:0]     addend_q, addend_d;
  logic [23:0]     score_q, score_d;
  logic [1:0]      combo_q, combo_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [23:0]     fifo_q [FIFO_DEPTH];
  logic [23:0]     fifo_d [FIFO_DEPTH];
  logic [6:0]      hex_q [8];
  logic [6:0]      hex_d [8];
`ifdef SCORE_HISCORE_EN
  logic [23:0]     hiscore_q, hiscore_d;
`endif

  logic            item_ok, is_energizer, pop, push_item, push_ghost;
  logic [23:0]     item_val, ghost_val, disp;
  logic [1:0]      ghost_n;
  logic [CW-1:0]   free;
  logic [AW-1:0]   wp;
  logic [4:0]      idx, sum;
  logic [7:0]      lvl;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    carry_d    = carry_q;
    addend_d   = addend_q;
    score_d    = score_q;
    combo_d    = combo_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;
`ifdef SCORE_HISCORE_EN
    hiscore_d  = hiscore_q;
`endif

    item_ok      = i_item_eaten && (i_item_eaten_type == 2'd1 || i_item_eaten_type == 2'd2);
    is_energizer = i_item_eaten && (i_item_eaten_type == 2'd2);
    item_val     = is_energizer ? 24'h000050 : 24'h000010;
    // An energizer in the same cycle restarts the combo before the ghost is valued.
    ghost_n      = is_energizer ? 2'd0 : combo_q;
    case (ghost_n)
      2'd0:    ghost_val = 24'h000200;
      2'd1:    ghost_val = 24'h000400;
      2'd2:    ghost_val = 24'h000800;
      default: ghost_val = 24'h001600;
    endcase
    if (i_ghost_eaten)
      combo_d = (ghost_n == 2'd3) ? 2'd3 : ghost_n + 2'd1;
    else if (is_energizer)
      combo_d = 2'd0;

    pop = (state_q == S_IDLE) && (count_q != '0);
    idx = {digit_q, 2'b00};
    sum = 5'(score_q[idx +: 4]) + 5'(addend_q[idx +: 4]) + 5'(carry_q);

    if (pop) begin
      addend_d = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
      digit_d  = 3'd0;
      carry_d  = 1'b0;
      state_d  = S_ADD;
    end else if (state_q == S_ADD) begin
      if (sum > 5'd9) begin
        score_d[idx +: 4] = 4'(sum - 5'd10);
        carry_d           = 1'b1;
      end else begin
        score_d[idx +: 4] = sum[3:0];
        carry_d           = 1'b0;
      end
      if (digit_q == 3'd5) begin
        state_d = S_IDLE;
        if (sum > 5'd9) score_d = 24'h999999;
      end else begin
        digit_d = digit_q + 3'd1;
      end
    end

    // Free space counts the slot released by a pop in this same cycle.
    free       = CW'(FIFO_DEPTH) - count_q + CW'(pop);
    push_item  = item_ok && (free != '0);
    push_ghost = i_ghost_eaten && (free > CW'(push_item));
    if ((item_ok && !push_item) || (i_ghost_eaten && !push_ghost)) overflow_d = 1'b1;

    wp = wr_ptr_q;
    if (push_item) begin
      fifo_d[wp] = item_val;
      wp         = wp + AW'(1);
    end
    if (push_ghost) begin
      fifo_d[wp] = ghost_val;
      wp         = wp + AW'(1);
    end
    wr_ptr_d = wp;
    count_d  = count_q - CW'(pop) + CW'(push_item) + CW'(push_ghost);

    if (i_score_reset) begin
`ifdef SCORE_HISCORE_EN
      if (score_q > hiscore_q) hiscore_d = score_q;
`endif
      state_d    = S_IDLE;
      digit_d    = 3'd0;
      carry_d    = 1'b0;
      score_d    = '0;
      combo_d    = 2'd0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
    busy_d = (count_d != '0) || (state_d == S_ADD);

    disp = score_q;
`ifdef SCORE_HISCORE_EN
    if (i_show_hiscore) disp = hiscore_q;
`endif
    lvl = (i_level > 8'd99) ? 8'd99 : i_level;
    for (int i = 0; i < 6; i++) hex_d[i] = seg(disp[4*i +: 4]);
    hex_d[6] = seg(4'(lvl % 8'd10));
    hex_d[7] = seg(4'(lvl / 8'd10));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      digit_q    <= 3'd0;
      carry_q    <= 1'b0;
      addend_q   <= '0;
      score_q    <= '0;
      combo_q    <= 2'd0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < 8; i++) hex_q[i] <= 7'b1000000;
`ifdef SCORE_HISCORE_EN
      hiscore_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      carry_q    <= carry_d;
      addend_q   <= addend_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
      hex_q      <= hex_d;
`ifdef SCORE_HISCORE_EN
      hiscore_q  <= hiscore_d;
`endif
    end
  end

  assign o_score      = score_q;
  assign o_busy       = busy_q;
  assign o_overflow   = overflow_q;
  assign o_dbg_adding = (state_q == S_ADD);
  assign o_hex0       = hex_q[0];
  assign o_hex1       = hex_q[1];
  assign o_hex2       = hex_q[2];
  assign o_hex3       = hex_q[3];
  assign o_hex4       = hex_q[4];
  assign o_hex5       = hex_q[5];
  assign o_hex6       = hex_q[6];
  assign o_hex7       = hex_q[7];
`ifdef SCORE_HISCORE_EN
  assign o_hiscore    = hiscore_q;
`endif

endmodule

// File: doc/score_display.md
# score_display

Scoring stage downstream of the collision and item controllers. Converts per-cycle eaten events into Pac-Man points, accumulates a 6-digit BCD score with a digit-serial adder fed from a small event FIFO, and drives the eight seven-segment displays: score on HEX0–HEX5, level on HEX6–HEX7. Replaces the constant HEX assignments in the board top level.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: pending-addend FIFO entries; must be a power of two, at least 2.

Ports:
- `i_clk`  in  1  system clock, 50 MHz.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_score_reset`  in  1  synchronous clear of score, FIFO, combo and adder; pulse from the game controller on new game.
- `i_item_eaten`  in  1  one-cycle pulse from the collision controller.
- `i_item_eaten_type`  in  2  item type: 1 dot, 2 energizer; 0 and 3 score nothing.
- `i_ghost_eaten`  in  1  one-cycle pulse, OR of the four ghost-eaten flags.
- `i_level`  in  8  binary level from the game controller.
- `o_score`  out  24  6 BCD digits; [3:0] is the units digit.
- `o_busy`  out  1  adder active or FIFO non-empty.
- `o_overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `o_hex0` … `o_hex7`  out  7 each  active-low segments; bit0 = a … bit6 = g.

## Operation
- Points: dot adds 10, energizer adds 50, ghost adds 200·2^n.
  - n is a 2-bit combo counter. It increments after each ghost event and saturates at 3, so the 4th and later ghosts score 1600.
  - The combo counter resets to 0 on each energizer event.
- Addend encoding: a BCD value (24 bit) pushed into the FIFO.
- When item and ghost events arrive in the same cycle, both are pushed: the item entry first, then the ghost entry. An energizer in that cycle resets the combo before the ghost value is computed, so that ghost scores 200.
- FIFO full: each entry that does not fit is dropped and `o_overflow` is set. Of a simultaneous pair, the item entry has priority.
- Adder FSM:
  - IDLE: if the FIFO is non-empty, pop into the addend register, set digit index d = 0 and carry = 0, and go to ADD.
  - ADD: add digit d of the addend to score digit d plus carry. If the sum is greater than 9, subtract 10 and set carry. Increment d. After d = 5, return to IDLE.
  - Saturation: a carry out of digit 5 forces the score to 999999.
- `i_score_reset` has priority over everything:
  - Clears the score, FIFO, combo, `o_overflow` and d, and returns the FSM to IDLE, aborting any add in progress.
  - Events in the same cycle are discarded.
- HEX0–HEX5 show the score digits, HEX0 = units, with no leading-zero blanking.
- HEX7:HEX6 show `i_level` as two decimal digits, HEX6 = units. Values above 99 display 99.
- Digit-to-segment encoding:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

## Timing
- Reset values:
  - `o_score` = 0, `o_busy` = 0, `o_overflow` = 0.
  - FSM in IDLE, combo = 0, FIFO empty.
  - `o_hex0`–`o_hex7` = 1000000 ("0").
- An event sampled at clock edge E0 is written to the FIFO at E0.
- Pop and load at E1; digit adds at E2–E7.
- `o_score` holds the new total after E7. Intermediate values are visible during E2–E7.
- Back-to-back events sustain one add per 7 cycles.
- HEX outputs are registered from `o_score` and `i_level`, one cycle behind them.
- `o_busy` is registered. It rises at E0 and falls at the edge after the last digit add when the FIFO is empty.
- A push and a pop in the same cycle are both honoured; full status is evaluated after the pop.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds port `i_show_hiscore` (in, 1) and port `o_hiscore` (out, 24, BCD).
  - On `i_score_reset`, `o_hiscore` loads the current score if that score is greater.
  - While `i_show_hiscore` = 1, HEX0–HEX5 display `o_hiscore`.
  - `o_hiscore` resets to 0 only on `i_rst_n`.
- `SCORE_HISCORE_EN` undefined: those ports and the hiscore register do not exist.

## Test plan
- Reset, then 3 dot pulses spaced 10 cycles apart → `o_score` = 0x000030, HEX1 = 0110000, HEX0 = 1000000.
- Energizer, then 5 ghost pulses spaced 8 cycles apart → total 50 + 200 + 400 + 800 + 1600 + 1600 = 4650, `o_score` = 0x004650.
- Dot pulses on 6 consecutive cycles with `FIFO_DEPTH` = 4 → `o_overflow` = 1; `o_score` = 0x000050 (5 accepted: 4 queued plus 1 popped).
- Preload by 20000 ghost-1600 events, then 1 dot → `o_score` stays 0x999999, never wraps.
- `i_score_reset` pulsed at E4 of an add in progress → next cycle `o_score` = 0, `o_busy` = 0, FSM in IDLE.
- `i_level` = 7 → HEX7 = 1000000, HEX6 = 1111000; `i_level` = 150 → HEX7 = HEX6 = 0010000.
